// File: rtl/fetch_pcgen.sv
// Fetch stage: owns the fetch PC, drives a hold-until-data instruction bus and
// fills the fetch/decode register, squashing wrong-path words on redirect.
module fetch_pcgen #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [63:0] pc_address,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT_FLUSH, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] saved_q, saved_d;
  logic [63:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        f_valid_q, f_valid_d;
  logic [63:0] f_pc_q, f_pc_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic        out_free;

  assign out_free = !f_valid_q || !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      saved_q      <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      f_valid_q    <= 1'b0;
      f_pc_q       <= '0;
      f_instr_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      saved_q      <= saved_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      f_instr_q    <= f_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    saved_d      = saved_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    f_valid_d    = f_valid_q && stall;
    f_pc_d       = f_pc_q;
    f_instr_d    = f_instr_q;
    case (state_q)
      S_FETCH: begin
        if (PCSel) begin
          if (iresp_data_ok) begin
            pc_d = pc_address;
          end else begin
            saved_d = pc_address;
            state_d = S_WAIT_FLUSH;
          end
        end else if (iresp_data_ok) begin
          if (out_free) begin
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            f_instr_d = iresp_data;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = iresp_data;
            state_d      = S_HOLD;
          end
          pc_d = pc_q + 64'd4;
        end
      end
      S_WAIT_FLUSH: begin
        // A redirect landing on the data_ok cycle beats the saved target.
        if (PCSel) saved_d = pc_address;
        if (iresp_data_ok) begin
          pc_d    = PCSel ? pc_address : saved_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (PCSel) begin
          pc_d    = pc_address;
          state_d = S_FETCH;
        end else if (!stall) begin
          f_valid_d = 1'b1;
          f_pc_d    = skid_pc_q;
          f_instr_d = skid_instr_q;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (PCSel) f_valid_d = 1'b0;
  end

  always_comb begin
    ireq_valid = (state_q != S_HOLD) && !reset;
    ireq_addr  = pc_q;
    f_valid    = f_valid_q;
    f_pc       = f_pc_q;
    f_instr    = f_instr_q;
  end

endmodule

// File: tb/tb_fetch_pcgen.sv
// Bench for fetch_pcgen: directed scenarios, then random bus/stall/redirect
// traffic scored against the architectural instruction stream.
module tb_fetch_pcgen;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        PCSel;
  logic [63:0] pc_address;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  logic [63:0] exp_q[$];
  bit          bus_pending = 0;
  logic [63:0] bus_addr = '0;

  fetch_pcgen #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .stall(stall), .PCSel(PCSel), .pc_address(pc_address),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Memory: the word for whatever address is on the bus.
  always_comb iresp_data = mem_word(ireq_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A redirect discards everything not yet consumed; the stream restarts at the target.
  task automatic redirect(input logic [63:0] tgt);
    PCSel      = 1'b1;
    pc_address = tgt;
    exp_q.delete();
    exp_q.push_back(tgt);
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'hFFFF_FFFF_FFFF_FFF8;
      1:       t = RESET_PC + 64'($urandom_range(0, 255) * 4);
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  // Monitor: bus stability plus in-order consumption scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      bus_pending = 0;
    end else begin
      if (bus_pending) begin
        chk("bus_hold_valid", 64'(ireq_valid), 64'd1);
        chk("bus_hold_addr", ireq_addr, bus_addr);
      end
      bus_pending = ireq_valid && !iresp_data_ok;
      bus_addr    = ireq_addr;
      if (f_valid && !stall && !PCSel) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got f_pc %h expected no output", f_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_f_pc", f_pc, e);
          chk("sb_f_instr", 64'(f_instr), 64'(mem_word(e)));
          exp_q.push_back(e + 64'd4);
          consumed++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; PCSel = 1'b0; pc_address = '0; iresp_data_ok = 1'b0;
    exp_q.push_back(RESET_PC);
    repeat (2) cyc();
    chk("reset_ireq_valid", 64'(ireq_valid), 64'd0);
    chk("reset_f_valid", 64'(f_valid), 64'd0);
    chk("reset_f_pc", f_pc, 64'd0);
    chk("reset_f_instr", 64'(f_instr), 64'd0);
    reset = 1'b0;
    #1;
    chk("first_req_valid", 64'(ireq_valid), 64'd1);
    chk("first_req_addr", ireq_addr, RESET_PC);

    // Back-to-back data_ok
    iresp_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("b2b_addr", ireq_addr, RESET_PC + 64'(4 * i));
      cyc();
      chk("b2b_f_valid", 64'(f_valid), 64'd1);
      chk("b2b_f_pc", f_pc, RESET_PC + 64'(4 * i));
    end

    // Stall while the next word returns -> skid/HOLD
    chk("skid_req_addr", ireq_addr, RESET_PC + 64'h8);
    stall = 1'b1;
    cyc();
    iresp_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ireq_valid", 64'(ireq_valid), 64'd0);
      chk("hold_f_pc", f_pc, RESET_PC + 64'h4);
      if (i < 2) cyc();
    end
    stall = 1'b0;
    cyc();
    chk("release_f_pc", f_pc, RESET_PC + 64'h8);
    chk("release_f_instr", 64'(f_instr), 64'(mem_word(RESET_PC + 64'h8)));
    chk("release_req_valid", 64'(ireq_valid), 64'd1);
    chk("release_req_addr", ireq_addr, RESET_PC + 64'hC);

    // Redirect from HOLD (nothing in flight), overriding stall
    stall = 1'b1; iresp_data_ok = 1'b1;
    cyc();
    iresp_data_ok = 1'b0;
    chk("hold2_ireq_valid", 64'(ireq_valid), 64'd0);
    redirect(RESET_PC + 64'h100);
    cyc();
    PCSel = 1'b0; stall = 1'b0;
    chk("redir_idle_f_valid", 64'(f_valid), 64'd0);
    chk("redir_idle_addr", ireq_addr, RESET_PC + 64'h100);

    // Redirect while the request waits 4 cycles
    redirect(RESET_PC + 64'h200);
    cyc();
    PCSel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_addr_held", ireq_addr, RESET_PC + 64'h100);
      chk("flush_f_valid", 64'(f_valid), 64'd0);
      cyc();
    end
    iresp_data_ok = 1'b1;
    cyc();
    iresp_data_ok = 1'b0;
    chk("flush_word_dropped", 64'(f_valid), 64'd0);
    chk("flush_new_addr", ireq_addr, RESET_PC + 64'h200);

    // Redirect on the data_ok cycle with stall high
    iresp_data_ok = 1'b1;
    cyc();
    chk("pre_same_f_pc", f_pc, RESET_PC + 64'h200);
    stall = 1'b1;
    redirect(RESET_PC + 64'h300);
    cyc();
    PCSel = 1'b0; iresp_data_ok = 1'b0; stall = 1'b0;
    chk("same_cyc_f_valid", 64'(f_valid), 64'd0);
    chk("same_cyc_addr", ireq_addr, RESET_PC + 64'h300);

    // Reset during WAIT_FLUSH
    redirect(RESET_PC + 64'h400);
    cyc();
    PCSel = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    #1;
    chk("midreset_f_valid", 64'(f_valid), 64'd0);
    chk("midreset_f_pc", f_pc, 64'd0);
    chk("midreset_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("postreset_addr", ireq_addr, RESET_PC);
    iresp_data_ok = 1'b1;
    cyc();
    chk("postreset_f_pc", f_pc, RESET_PC);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      PCSel         = 1'b0;
      stall         = ($urandom_range(0, 3) == 0);
      iresp_data_ok = ireq_valid && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) redirect(pick_target());
      cyc();
    end
    PCSel = 1'b0; stall = 1'b1; iresp_data_ok = 1'b0;
    cyc();
    chk("progress", 64'(consumed > 500), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
